// File: rtl/sfp_wb_arbiter_pkg.sv
// Shared definitions for the SFP EEPROM Wishbone arbiter: FSM encoding and a
// constant-evaluable ceil(log2) helper used for parameter-derived widths.
package sfp_wb_arbiter_pkg;

    typedef enum logic [1:0] {
        s_Idle    = 2'd0,
        s_Granted = 2'd1,
        s_Abort   = 2'd2
    } arb_state_e;

    // Smallest w such that 2**w >= value; usable in localparam expressions.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int p = 1; p < value; p = p * 2) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sfp_wb_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: searches the request vector starting one
// position after the previous winner, wrapping, and returns the first hit.
module rr_priority_picker
    import sfp_wb_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    logic [IW-1:0] cand_s;
    logic          hit_s;

    // Walk the ring once; the first requester found after last_i wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand_s  = '0;
        hit_s   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand_s         = IW'((int'(last_i) + k) % N);
            hit_s          = !valid_o && req_i[cand_s];
            gnt_o[cand_s]  = gnt_o[cand_s] | hit_s;
            idx_o          = hit_s ? cand_s : idx_o;
            valid_o        = valid_o | hit_s;
        end
    end

endmodule

// File: rtl/sfp_wb_arbiter.sv
// Round-robin Wishbone arbiter sharing the SFP EEPROM read port between byte
// readers; holds a grant for a whole Cyc and aborts hung transfers on timeout.
module sfp_wb_arbiter
    import sfp_wb_arbiter_pkg::*;
#(
    parameter int g_NumMasters    = 4,
    parameter int g_WbAddrWidth   = 32,
    parameter int g_TimeoutCycles = 65535
) (
    input  logic                                  Clk_ik,
    input  logic                                  Rst_ir,
    input  logic [g_NumMasters-1:0]               WbCyc_ib,
    input  logic [g_NumMasters-1:0]               WbStb_ib,
    input  logic [g_NumMasters*g_WbAddrWidth-1:0] WbAddr_ib,
    output logic [7:0]                            WbData_ob8,
    output logic [g_NumMasters-1:0]               WbAck_ob,
    output logic [g_NumMasters-1:0]               WbErr_ob,
    output logic                                  WbCyc_o,
    output logic                                  WbStb_o,
    output logic [g_WbAddrWidth-1:0]              WbAddr_ob,
    input  logic [7:0]                            WbData_ib8,
    input  logic                                  WbAck_i,
    output logic [g_NumMasters-1:0]               Grant_ob
);

    localparam int N  = g_NumMasters;
    localparam int AW = g_WbAddrWidth;
    localparam int IW = clog2(N);
    localparam int CW = clog2(g_TimeoutCycles + 1);

    localparam logic [CW-1:0] CntMax  = CW'(g_TimeoutCycles);
    localparam logic [CW-1:0] CntLast = CW'(g_TimeoutCycles - 1);
    localparam logic [IW-1:0] LastRst = IW'(N - 1);

    arb_state_e    state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [N-1:0]  err_q, err_d;
    logic [IW-1:0] last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [N-1:0]  pick_gnt_s;
    logic [IW-1:0] pick_idx_s;
    logic          pick_valid_s;

    logic          sel_cyc_s;
    logic          sel_stb_s;
    logic [AW-1:0] sel_addr_s;
    logic          timeout_s;

    rr_priority_picker #(
        .N  (N),
        .IW (IW)
    ) u_picker (
        .req_i   (WbCyc_ib),
        .last_i  (last_q),
        .gnt_o   (pick_gnt_s),
        .idx_o   (pick_idx_s),
        .valid_o (pick_valid_s)
    );

    // One-hot AND-OR mux selecting the granted master's Cyc/Stb/address.
    always_comb begin
        sel_cyc_s  = 1'b0;
        sel_stb_s  = 1'b0;
        sel_addr_s = '0;
        for (int i = 0; i < N; i++) begin
            sel_cyc_s  = sel_cyc_s | (grant_q[i] & WbCyc_ib[i]);
            sel_stb_s  = sel_stb_s | (grant_q[i] & WbStb_ib[i]);
            sel_addr_s = sel_addr_s | ({AW{grant_q[i]}} & WbAddr_ib[i*AW +: AW]);
        end
    end

    // Slave-side outputs follow the owner only while granted; abort and idle keep the slave quiet.
    always_comb begin
        WbCyc_o   = 1'b0;
        WbStb_o   = 1'b0;
        WbAddr_ob = '0;
        WbAck_ob  = '0;
        if (state_q == s_Granted) begin
            WbCyc_o   = sel_cyc_s;
            WbStb_o   = sel_stb_s;
            WbAddr_ob = sel_addr_s;
            WbAck_ob  = grant_q & {N{WbAck_i}};
        end else begin
            WbCyc_o   = 1'b0;
            WbStb_o   = 1'b0;
        end
    end

    assign WbData_ob8 = WbData_ib8;
    assign Grant_ob   = grant_q;
    assign WbErr_ob   = err_q;

    // The limit fires on the edge that would complete the last unacknowledged Stb cycle;
    // an Ack in that same cycle wins.
    assign timeout_s = WbStb_o && !WbAck_i && (cnt_q >= CntLast);

    // Saturating Stb-without-Ack counter.
    always_comb begin
        cnt_d = cnt_q;
        if (!WbStb_o || WbAck_i) begin
            cnt_d = '0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Next-state logic: grant on request, release on Cyc drop, abort on timeout.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        err_d   = err_q;
        last_d  = last_q;
        case (state_q)
            s_Idle: begin
                if (pick_valid_s) begin
                    state_d = s_Granted;
                    grant_d = pick_gnt_s;
                    last_d  = pick_idx_s;
                end else begin
                    state_d = s_Idle;
                end
            end
            s_Granted: begin
                if (!sel_cyc_s) begin
                    state_d = s_Idle;
                    grant_d = '0;
                end else if (timeout_s) begin
                    state_d = s_Abort;
                    err_d   = grant_q;
                end else begin
                    state_d = s_Granted;
                end
            end
            s_Abort: begin
                if (!sel_cyc_s) begin
                    state_d = s_Idle;
                    grant_d = '0;
                    err_d   = '0;
                end else begin
                    state_d = s_Abort;
                end
            end
            default: begin
                state_d = s_Idle;
                grant_d = '0;
                err_d   = '0;
            end
        endcase
    end

    // State, grant, error and counter registers.
    always_ff @(posedge Clk_ik or posedge Rst_ir) begin
        if (Rst_ir) begin
            state_q <= s_Idle;
            grant_q <= '0;
            err_q   <= '0;
            last_q  <= LastRst;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            err_q   <= err_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sfp_wb_arbiter.sv
// Directed self-checking bench for sfp_wb_arbiter (4 masters, timeout of 10).
module tb_sfp_wb_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int TO = 10;

    logic            Clk_ik = 1'b0;
    logic            Rst_ir;
    logic [N-1:0]    WbCyc_ib;
    logic [N-1:0]    WbStb_ib;
    logic [N*AW-1:0] WbAddr_ib;
    logic [7:0]      WbData_ob8;
    logic [N-1:0]    WbAck_ob;
    logic [N-1:0]    WbErr_ob;
    logic            WbCyc_o;
    logic            WbStb_o;
    logic [AW-1:0]   WbAddr_ob;
    logic [7:0]      WbData_ib8;
    logic            WbAck_i;
    logic [N-1:0]    Grant_ob;

    int total = 0;
    int bad   = 0;
    int acks0 = 0;

    sfp_wb_arbiter #(
        .g_NumMasters    (N),
        .g_WbAddrWidth   (AW),
        .g_TimeoutCycles (TO)
    ) dut (
        .Clk_ik     (Clk_ik),
        .Rst_ir     (Rst_ir),
        .WbCyc_ib   (WbCyc_ib),
        .WbStb_ib   (WbStb_ib),
        .WbAddr_ib  (WbAddr_ib),
        .WbData_ob8 (WbData_ob8),
        .WbAck_ob   (WbAck_ob),
        .WbErr_ob   (WbErr_ob),
        .WbCyc_o    (WbCyc_o),
        .WbStb_o    (WbStb_o),
        .WbAddr_ob  (WbAddr_ob),
        .WbData_ib8 (WbData_ib8),
        .WbAck_i    (WbAck_i),
        .Grant_ob   (Grant_ob)
    );

    always #5 Clk_ik = ~Clk_ik;

    task automatic tick;
        @(posedge Clk_ik);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Owner m is granted: ack one byte, then drop its Cyc and see the idle cycle.
    task automatic serve(input int m);
        WbAck_i = 1'b1;
        #1;
        chk("serve_ack", WbAck_ob, 32'(1 << m));
        tick;
        WbAck_i     = 1'b0;
        WbCyc_ib[m] = 1'b0;
        WbStb_ib[m] = 1'b0;
        #1;
        chk("serve_grant_hold", Grant_ob, 32'(1 << m));
        tick;
        chk("serve_idle_grant", Grant_ob, 32'd0);
        chk("serve_idle_cyc", WbCyc_o, 32'd0);
    endtask

    initial begin
        Rst_ir     = 1'b1;
        WbCyc_ib   = '0;
        WbStb_ib   = '0;
        WbAddr_ib  = '0;
        WbData_ib8 = 8'h5A;
        WbAck_i    = 1'b0;
        tick;
        tick;
        chk("rst_grant", Grant_ob, 32'd0);
        chk("rst_err", WbErr_ob, 32'd0);
        chk("rst_cyc", WbCyc_o, 32'd0);
        chk("rst_stb", WbStb_o, 32'd0);
        chk("rst_addr", WbAddr_ob, 32'd0);
        chk("rst_ack", WbAck_ob, 32'd0);
        chk("rst_data", WbData_ob8, 32'h5A);
        Rst_ir = 1'b0;

        // Single master 0 reads 40..55, slave acks on the third Stb cycle.
        WbCyc_ib = 4'b0001;
        WbStb_ib = 4'b0001;
        WbAddr_ib[0 +: AW] = 32'd40;
        #1;
        chk("t1_pre_grant", Grant_ob, 32'd0);
        chk("t1_pre_cyc", WbCyc_o, 32'd0);
        tick;
        chk("t1_latency_cyc", WbCyc_o, 32'd1);
        for (int i = 0; i < 16; i++) begin
            WbAddr_ib[0 +: AW] = 32'(40 + i);
            WbData_ib8 = 8'(8'hA0 + i);
            WbAck_i = 1'b0;
            #1;
            chk("t1_addr", WbAddr_ob, 32'(40 + i));
            chk("t1_grant", Grant_ob, 32'd1);
            chk("t1_noack", WbAck_ob, 32'd0);
            tick;
            tick;
            WbAck_i = 1'b1;
            #1;
            chk("t1_ack", WbAck_ob, 32'd1);
            chk("t1_data", WbData_ob8, 32'(8'hA0 + i));
            acks0 = acks0 + ((WbAck_ob == 4'b0001) ? 1 : 0);
            tick;
        end
        chk("t1_ack_count", acks0, 32'd16);
        WbAck_i  = 1'b0;
        WbCyc_ib = 4'b0000;
        WbStb_ib = 4'b0000;
        #1;
        chk("t1_grant_before_edge", Grant_ob, 32'd1);
        tick;
        chk("t1_grant_released", Grant_ob, 32'd0);
        chk("t1_cyc_released", WbCyc_o, 32'd0);

        // All four request together from reset: strict rotation 0,1,2,3.
        Rst_ir = 1'b1;
        tick;
        Rst_ir = 1'b0;
        for (int m = 0; m < N; m++) begin
            WbAddr_ib[m*AW +: AW] = 32'(100 + m);
        end
        WbCyc_ib = 4'b1111;
        WbStb_ib = 4'b1111;
        for (int o = 0; o < N; o++) begin
            tick;
            chk("t2_grant", Grant_ob, 32'(1 << o));
            chk("t2_addr", WbAddr_ob, 32'(100 + o));
            chk("t2_cyc", WbCyc_o, 32'd1);
            tick;
            chk("t2_grant_held", Grant_ob, 32'(1 << o));
            serve(o);
        end

        // Master 2 served, then 1 and 3 together: 3 first, then 1.
        WbCyc_ib = 4'b0100;
        WbStb_ib = 4'b0100;
        tick;
        chk("t3_grant2", Grant_ob, 32'h4);
        serve(2);
        WbCyc_ib = 4'b1010;
        WbStb_ib = 4'b1010;
        tick;
        chk("t3_grant3_first", Grant_ob, 32'h8);
        serve(3);
        tick;
        chk("t3_grant1_second", Grant_ob, 32'h2);
        serve(1);

        // Master 2 hangs: abort after 10 Stb cycles, master 0 waits its turn.
        WbCyc_ib = 4'b0100;
        WbStb_ib = 4'b0100;
        WbAddr_ib[2*AW +: AW] = 32'd77;
        tick;
        chk("t4_grant", Grant_ob, 32'h4);
        WbCyc_ib = 4'b0101;
        WbStb_ib = 4'b0101;
        for (int c = 2; c <= TO; c++) begin
            tick;
        end
        chk("t4_cyc_at_limit", WbCyc_o, 32'd1);
        chk("t4_err_at_limit", WbErr_ob, 32'd0);
        tick;
        chk("t4_abort_cyc", WbCyc_o, 32'd0);
        chk("t4_abort_stb", WbStb_o, 32'd0);
        chk("t4_abort_err", WbErr_ob, 32'h4);
        chk("t4_abort_ack", WbAck_ob, 32'd0);
        tick;
        tick;
        WbAck_i = 1'b1;
        #1;
        chk("t4_err_held", WbErr_ob, 32'h4);
        chk("t4_no_ack_in_abort", WbAck_ob, 32'd0);
        WbAck_i  = 1'b0;
        WbCyc_ib = 4'b0001;
        WbStb_ib = 4'b0001;
        tick;
        chk("t4_err_cleared", WbErr_ob, 32'd0);
        chk("t4_idle_grant", Grant_ob, 32'd0);
        tick;
        chk("t4_next_grant", Grant_ob, 32'h1);
        serve(0);

        // Ack lands on the 10th Stb cycle: delivered, no abort.
        WbCyc_ib = 4'b0010;
        WbStb_ib = 4'b0010;
        tick;
        chk("t5_grant", Grant_ob, 32'h2);
        for (int c = 2; c <= TO; c++) begin
            tick;
        end
        WbAck_i = 1'b1;
        #1;
        chk("t5_ack", WbAck_ob, 32'h2);
        chk("t5_no_err", WbErr_ob, 32'd0);
        tick;
        WbAck_i = 1'b0;
        #1;
        chk("t5_still_cyc", WbCyc_o, 32'd1);
        chk("t5_no_err_after", WbErr_ob, 32'd0);
        chk("t5_still_granted", Grant_ob, 32'h2);
        WbCyc_ib = 4'b0000;
        WbStb_ib = 4'b0000;
        tick;
        chk("t5_released", Grant_ob, 32'd0);

        // Reset mid-transfer of master 2; afterwards master 0 wins contention.
        WbCyc_ib = 4'b0100;
        WbStb_ib = 4'b0100;
        tick;
        chk("t6_grant2", Grant_ob, 32'h4);
        chk("t6_cyc", WbCyc_o, 32'd1);
        Rst_ir   = 1'b1;
        WbCyc_ib = 4'b1111;
        WbStb_ib = 4'b1111;
        #1;
        chk("t6_rst_cyc", WbCyc_o, 32'd0);
        chk("t6_rst_stb", WbStb_o, 32'd0);
        chk("t6_rst_grant", Grant_ob, 32'd0);
        tick;
        Rst_ir = 1'b0;
        tick;
        chk("t6_after_rst_grant", Grant_ob, 32'h1);
        chk("t6_after_rst_addr", WbAddr_ob, 32'd100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sfp_wb_arbiter.md
# sfp_wb_arbiter

Round-robin Wishbone arbiter that shares the single 8-bit read port of the I2C-mux SFP EEPROM slave between up to g_NumMasters byte-reading requesters (per-port SFP ID readers, diagnostics readers). It sits between those masters and the I2C-mux Wishbone slave and holds a grant for a whole Cyc. It adds a bus-timeout watchdog so a hung I2C transaction cannot lock out the other ports.

## Interface
Parameters:
- g_NumMasters, 4, number of requesters (2..8)
- g_WbAddrWidth, 32, address width of each master and of the slave port
- g_TimeoutCycles, 65535, Stb-without-Ack cycles before abort (1..2^20-1)

Ports:
- Clk_ik  input  1  system clock; one clock domain
- Rst_ir  input  1  reset; asynchronous, active-high
- WbCyc_ib  input  g_NumMasters  per-master Cyc
- WbStb_ib  input  g_NumMasters  per-master Stb
- WbAddr_ib  input  g_NumMasters*g_WbAddrWidth  packed addresses; master i at bits [i*AW +: AW]
- WbData_ob8  output  8  slave read data broadcast to all masters
- WbAck_ob  output  g_NumMasters  per-master Ack
- WbErr_ob  output  g_NumMasters  per-master timeout error
- WbCyc_o  output  1  slave Cyc
- WbStb_o  output  1  slave Stb
- WbAddr_ob  output  g_WbAddrWidth  slave address
- WbData_ib8  input  8  slave read data
- WbAck_i  input  1  slave Ack
- Grant_ob  output  g_NumMasters  one-hot current grant, all zero when idle

## Operation
- States: s_Idle, s_Granted, s_Abort.
- s_Idle: if any WbCyc_ib bit is set, grant the first requester found searching from (LastGrant+1) mod N upward with wrap-around. Register Grant_ob and LastGrant, then go to s_Granted. No request: stay.
- s_Granted: WbCyc_o = WbCyc_ib[g]; WbStb_o = WbStb_ib[g]; WbAddr_ob = master g's address (combinational mux on registered grant). WbAck_ob[g] = WbAck_i; other Ack bits 0.
  - Master g drops Cyc: go to s_Idle; Grant_ob clears on that edge.
  - Timeout counter reaches g_TimeoutCycles: go to s_Abort.
- Timeout counter: clears when WbStb_o = 0 or WbAck_i = 1, increments otherwise, saturating. Width is ceil(log2(g_TimeoutCycles+1)).
- s_Abort: WbCyc_o and WbStb_o forced 0; WbErr_ob[g] = 1; WbAck_ob = 0. Stay until master g drops Cyc, then go to s_Idle and clear WbErr_ob.
- WbData_ob8 = WbData_ib8 always. Masters qualify data with their own Ack.
- Non-granted masters see no Ack/Err and simply wait. There is no preemption.
- Simultaneous requests resolve by rotation. After master i is served, master i has lowest priority.
- LastGrant resets to N-1, so master 0 wins the first contention.

## Timing
- Reset values: Grant_ob = 0, WbErr_ob = 0, WbCyc_o = 0, WbStb_o = 0, WbAddr_ob = 0, WbAck_ob = 0, LastGrant = N-1, counter = 0, state s_Idle.
- Asserting Rst_ir mid-transfer drops slave Cyc/Stb immediately (asynchronous) and discards the grant.
- Grant latency: Cyc sampled high at edge k gives WbCyc_o high after edge k, i.e. 1 cycle.
- Ack/Err path slave→master: combinational, 0 cycles.
- Release: granted Cyc low at edge k means Grant_ob = 0 after edge k. The next grant comes after edge k+1, so there is one idle cycle between owners.
- Abort: counter equal to g_TimeoutCycles at edge k means WbErr_ob[g] = 1 and WbCyc_o = 0 after edge k.
- An Ack arriving in the same cycle the limit is reached takes priority: no abort.

## Structure
- Shared package holds the state encoding constants (s_Idle = 0, s_Granted = 1, s_Abort = 2) and a clog2 function.
- One sub-module: rr_priority_picker (N-bit request, last-grant index in; one-hot grant plus index out; purely combinational).
- FSM, counter and muxes live in the top.

## Test plan
- Single master 0 reads addr 40..55 with slave Ack 2 cycles after Stb:
  - WbAddr_ob tracks master 0.
  - Grant_ob = 4'b0001 throughout.
  - 16 Acks delivered only to master 0.
  - Grant_ob = 0 one cycle after Cyc drops.
- Masters 0..3 request together from reset:
  - Grants in order 0,1,2,3, each held for the full Cyc.
  - Exactly one idle cycle between owners.
- Master 2 served, then masters 1 and 3 request together:
  - Master 3 granted first, then master 1.
- Slave never Acks, g_TimeoutCycles = 10:
  - After 10 Stb cycles WbCyc_o = 0 and WbErr_ob = 4'b0100 (master 2).
  - Err held until master 2 drops Cyc.
  - The next requester is then granted.
- Ack arrives on cycle 10 with g_TimeoutCycles = 10:
  - Normal Ack is delivered.
  - No WbErr_ob.
- Rst_ir pulsed mid-transfer:
  - WbCyc_o, WbStb_o and Grant_ob are 0 in the same cycle.
  - After release, master 0 wins contention.
